icache_data_store: RTL

- Data-array side of the 2-way set-associative instruction cache.
- Accepts the line-fill write stream the program sequencer produces during a hold: one word per cycle, with line, entry and offset.
- Serves the sequencer's read selection (line, entry, offset) as a registered instruction word.
- Tracks per-word fill status and checks the fill stream for protocol violations.

---
 rtl/icache_data_store.sv | 125 ++++++++++++
 1 files changed

// File: rtl/icache_data_store.sv
// Data array of the 2-way instruction cache: line-fill write port, registered read port,
// per-word valid mask and a fill-stream protocol checker.
module icache_data_store #(
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 3
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic                cache_wren,
  input  logic                cache_wrline,
  input  logic                cache_wrentry,
  input  logic [OFFSET_W-1:0] cache_wroffset,
  input  logic [DATA_W-1:0]   rom_data,
  input  logic                cache_rdline,
  input  logic                cache_rdentry,
  input  logic [OFFSET_W-1:0] cache_rdoffset,
  output logic [DATA_W-1:0]   instr,
  output logic                instr_valid,
  output logic                fill_done,
  output logic                fill_err
);

  // state   | meaning
  // IDLE    | no fill in progress; next wren starts a fill and clears the target way
  // FILLING | burst active; each wren is checked against latched way and expected offset

  localparam int WORDS = 1 << OFFSET_W;
  localparam int DEPTH = 4 * WORDS;
  localparam int AW    = OFFSET_W + 2;
  localparam logic [OFFSET_W:0] BURST_MAX = (OFFSET_W+1)'(WORDS);

  typedef enum logic {IDLE, FILLING} state_t;

  state_t                state;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]      mask;
  logic                  fill_line;
  logic                  fill_entry;
  logic [OFFSET_W-1:0]   exp_off;
  logic [OFFSET_W:0]     burst_cnt;

  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         wr_way_base;
  logic [AW-1:0]         fill_way_base;
  logic [WORDS-1:0]      fill_way_mask;
  logic [WORDS-1:0]      wr_bit;
  logic                  hit_latched;
  logic                  seq_bad;

  assign wr_addr       = {cache_wrline, cache_wrentry, cache_wroffset};
  assign rd_addr       = {cache_rdline, cache_rdentry, cache_rdoffset};
  assign wr_way_base   = {cache_wrline, cache_wrentry, {OFFSET_W{1'b0}}};
  assign fill_way_base = {fill_line, fill_entry, {OFFSET_W{1'b0}}};
  assign fill_way_mask = mask[fill_way_base +: WORDS];
  assign wr_bit        = WORDS'(1) << cache_wroffset;
  assign hit_latched   = (cache_wrline == fill_line) && (cache_wrentry == fill_entry);
  assign seq_bad       = (cache_wroffset != exp_off) || !hit_latched || (burst_cnt == BURST_MAX);

  // Array has no reset; a write coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (cache_wren && !sync_reset)
      mem[wr_addr] <= rom_data;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (cache_wren && (wr_addr == rd_addr)) begin
      instr       <= rom_data;
      instr_valid <= 1'b1;
    end else begin
      instr       <= mem[rd_addr];
      instr_valid <= mask[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state      <= IDLE;
      mask       <= '0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
      fill_line  <= 1'b0;
      fill_entry <= 1'b0;
      exp_off    <= '0;
      burst_cnt  <= '0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cache_wren) begin
            state      <= FILLING;
            fill_line  <= cache_wrline;
            fill_entry <= cache_wrentry;
            exp_off    <= cache_wroffset + 1'b1;
            burst_cnt  <= (OFFSET_W+1)'(1);
            // Stale words of the evicted tag go invalid; the later NBA sets the new word.
            mask[wr_way_base +: WORDS] <= '0;
            mask[wr_addr]              <= 1'b1;
            if (cache_wroffset != '0)
              fill_err <= 1'b1;
          end
        end
        FILLING: begin
          if (cache_wren) begin
            mask[wr_addr] <= 1'b1;
            exp_off       <= exp_off + 1'b1;
            if (burst_cnt != BURST_MAX)
              burst_cnt <= burst_cnt + 1'b1;
            if (seq_bad)
              fill_err <= 1'b1;
            if (hit_latched && !(&fill_way_mask) && (&(fill_way_mask | wr_bit)))
              fill_done <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
